// File: rtl/prop_monitor_pkg.sv
// Shared types and constants for the bounded-window property monitor.
package prop_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam int DEF_NUM_PROP = 4;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_BOUND    = 100;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/prop_monitor_if.sv
// Control and result bundle between the monitor and its driver.
interface prop_monitor_if
    import prop_monitor_pkg::*;
#(
    parameter int NUM_PROP = DEF_NUM_PROP,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int ID_W     = clog2_min1(NUM_PROP)
);
    logic                start;
    logic [NUM_PROP-1:0] prop_in;
    logic [NUM_PROP-1:0] prop_en;
    logic                busy;
    logic                done;
    logic                fail;
    logic [NUM_PROP-1:0] hit_sticky;
    logic [ID_W-1:0]     first_id;
    logic [CNT_W-1:0]    first_cyc;
    logic [CNT_W-1:0]    cyc_cnt;

    modport master (
        output start, prop_in, prop_en,
        input  busy, done, fail,
        input  hit_sticky, first_id,
        input  first_cyc, cyc_cnt
    );

    modport slave (
        input  start, prop_in, prop_en,
        output busy, done, fail,
        output hit_sticky, first_id,
        output first_cyc, cyc_cnt
    );
endinterface

// File: rtl/prop_prio_enc.sv
// Lowest-set-bit priority encoder with valid flag.
module prop_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

    assign valid_o = |req_i;
endmodule

// File: rtl/prop_monitor.sv
// Bounded-window property observer: runs BOUND cycles after start,
// stops on the first masked hit and reports where it happened.
module prop_monitor
    import prop_monitor_pkg::*;
#(
    parameter int NUM_PROP = DEF_NUM_PROP,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int BOUND    = DEF_BOUND,
    parameter int ID_W     = clog2_min1(NUM_PROP)
) (
    input logic           clk,
    input logic           reset,
    prop_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BOUND - 1);

    state_e              state_q;
    logic                busy_q, done_q, fail_q;
    logic [NUM_PROP-1:0] sticky_q;
    logic [ID_W-1:0]     id_q;
    logic [CNT_W-1:0]    fcyc_q, cnt_q;

    logic [NUM_PROP-1:0] hit_d;
    logic [ID_W-1:0]     id_d;
    logic                hv_d;

    assign hit_d = bus.prop_in & bus.prop_en;

    prop_prio_enc #(.N(NUM_PROP), .W(ID_W)) u_enc (
        .req_i   (hit_d),
        .idx_o   (id_d),
        .valid_o (hv_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            sticky_q <= '0;
            id_q     <= '0;
            fcyc_q   <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    // A hit wins over the end-of-window pass.
                    if (hv_d) begin
                        state_q  <= ST_FAIL;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        fail_q   <= 1'b1;
                        sticky_q <= sticky_q | hit_d;
                        id_q     <= id_d;
                        fcyc_q   <= cnt_q;
                    end else if (cnt_q == LAST) begin
                        state_q <= ST_PASS;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (bus.start) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        fail_q   <= 1'b0;
                        sticky_q <= '0;
                        id_q     <= '0;
                        fcyc_q   <= '0;
                        cnt_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fail       = fail_q;
    assign bus.hit_sticky = sticky_q;
    assign bus.first_id   = id_q;
    assign bus.first_cyc  = fcyc_q;
    assign bus.cyc_cnt    = cnt_q;
endmodule
